// File: rtl/coin_collector.sv
// rtl/coin_collector.sv - coin and selection front-end feeding the vending machine core
//
// Purpose:
//   Counts inserted coins per denomination and handles refunds on cancel.
//   On a keypad selection it presents one transaction request to the core,
//   then blocks further input until the core has finished the service.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   coinValid      a coin is inserted this cycle
//   coinType       coin denomination: 00=50, 01=10, 10=5, 11=1
//   selValid       keypad selection strobe
//   selItem        item code: 00=NONE, 01=A, 10=B, 11=C
//   cancel         refund request
//   serviceTypeIn  core service state: 00=OFF, 01=ON, 10=BUSY, 11=not ON
//   coinInNTD_*    per-denomination coin counts presented to the core
//   itemTypeIn     requested item; it is non-NONE only while the request is pending
//   ready          high while coins and selections are accepted
//   creditValue    running credit value of the counted coins
//   coinReject     one-cycle pulse: the coin from the previous cycle was returned
//   refundValid    one-cycle pulse: a cancel completed
//   refundValue    refunded credit while refundValid is high, 0 otherwise
module coin_collector (
  input  logic       clk,
  input  logic       reset,
  input  logic       coinValid,
  input  logic [1:0] coinType,
  input  logic       selValid,
  input  logic [1:0] selItem,
  input  logic       cancel,
  input  logic [1:0] serviceTypeIn,
  output logic [1:0] coinInNTD_50,
  output logic [1:0] coinInNTD_10,
  output logic [1:0] coinInNTD_5,
  output logic [1:0] coinInNTD_1,
  output logic [1:0] itemTypeIn,
  output logic       ready,
  output logic [7:0] creditValue,
  output logic       coinReject,
  output logic       refundValid,
  output logic [7:0] refundValue
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } stateT;

  localparam logic [1:0] SVC_OFF   = 2'b00;
  localparam logic [1:0] SVC_ON    = 2'b01;
  localparam logic [1:0] ITEM_NONE = 2'b00;

  stateT state;

  // Counter values after taking this cycle's coin, if the coin fits.
  logic [1:0] next50, next10, next5, next1;
  logic       coinAccept;
  logic [7:0] nextCredit;

  // The maximum value is 3*50 + 3*10 + 3*5 + 3 = 198, so 8 bits never wrap.
  function automatic logic [7:0] creditOf(input logic [1:0] n50, input logic [1:0] n10,
                                          input logic [1:0] n5, input logic [1:0] n1);
    return ({6'd0, n50} * 8'd50) + ({6'd0, n10} * 8'd10) + ({6'd0, n5} * 8'd5) + {6'd0, n1};
  endfunction

  always_comb begin
    next50     = coinInNTD_50;
    next10     = coinInNTD_10;
    next5      = coinInNTD_5;
    next1      = coinInNTD_1;
    coinAccept = 1'b0;
    if (coinValid) begin
      case (coinType)
        2'b00: if (coinInNTD_50 != 2'd3) begin next50 = coinInNTD_50 + 2'd1; coinAccept = 1'b1; end
        2'b01: if (coinInNTD_10 != 2'd3) begin next10 = coinInNTD_10 + 2'd1; coinAccept = 1'b1; end
        2'b10: if (coinInNTD_5  != 2'd3) begin next5  = coinInNTD_5  + 2'd1; coinAccept = 1'b1; end
        default: if (coinInNTD_1 != 2'd3) begin next1 = coinInNTD_1 + 2'd1; coinAccept = 1'b1; end
      endcase
    end
    nextCredit = creditOf(next50, next10, next5, next1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= COLLECT;
      coinInNTD_50 <= 2'd0;
      coinInNTD_10 <= 2'd0;
      coinInNTD_5  <= 2'd0;
      coinInNTD_1  <= 2'd0;
      itemTypeIn   <= ITEM_NONE;
      ready        <= 1'b1;
      creditValue  <= 8'd0;
      coinReject   <= 1'b0;
      refundValid  <= 1'b0;
      refundValue  <= 8'd0;
    end else begin
      refundValid <= 1'b0;
      refundValue <= 8'd0;
      // Outside COLLECT every coin is handed back; COLLECT overrides below.
      coinReject  <= coinValid;
      case (state)
        COLLECT: begin
          coinReject <= coinValid && !coinAccept;
          if (cancel) begin
            // The refund includes a coin accepted in the same cycle.
            refundValid  <= 1'b1;
            refundValue  <= nextCredit;
            coinInNTD_50 <= 2'd0;
            coinInNTD_10 <= 2'd0;
            coinInNTD_5  <= 2'd0;
            coinInNTD_1  <= 2'd0;
            creditValue  <= 8'd0;
          end else begin
            coinInNTD_50 <= next50;
            coinInNTD_10 <= next10;
            coinInNTD_5  <= next5;
            coinInNTD_1  <= next1;
            creditValue  <= nextCredit;
            if (selValid && selItem != ITEM_NONE) begin
              itemTypeIn <= selItem;
              ready      <= 1'b0;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // The core samples the request on this edge when it is ON.
          if (serviceTypeIn == SVC_ON) begin
            coinInNTD_50 <= 2'd0;
            coinInNTD_10 <= 2'd0;
            coinInNTD_5  <= 2'd0;
            coinInNTD_1  <= 2'd0;
            creditValue  <= 8'd0;
            itemTypeIn   <= ITEM_NONE;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (serviceTypeIn == SVC_OFF) begin
            ready <= 1'b1;
            state <= COLLECT;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_collector.sv
// tb/tb_coin_collector.sv - self-checking bench for coin_collector
module tb_coin_collector;

  logic       clk;
  logic       reset;
  logic       coinValid;
  logic [1:0] coinType;
  logic       selValid;
  logic [1:0] selItem;
  logic       cancel;
  logic [1:0] serviceTypeIn;
  logic [1:0] coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1;
  logic [1:0] itemTypeIn;
  logic       ready;
  logic [7:0] creditValue;
  logic       coinReject;
  logic       refundValid;
  logic [7:0] refundValue;

  int passCount  = 0;
  int checkCount = 0;

  coin_collector dut (
    .clk(clk), .reset(reset), .coinValid(coinValid), .coinType(coinType),
    .selValid(selValid), .selItem(selItem), .cancel(cancel), .serviceTypeIn(serviceTypeIn),
    .coinInNTD_50(coinInNTD_50), .coinInNTD_10(coinInNTD_10), .coinInNTD_5(coinInNTD_5),
    .coinInNTD_1(coinInNTD_1), .itemTypeIn(itemTypeIn), .ready(ready),
    .creditValue(creditValue), .coinReject(coinReject), .refundValid(refundValid),
    .refundValue(refundValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: coin counts indexed by coinType, a phase, the pending item.
  localparam int P_COL  = 0;
  localparam int P_ISS  = 1;
  localparam int P_WAIT = 2;
  int         mCnt[4];
  int         mPhase;
  logic [1:0] mItem;
  logic       mRej, mRefV;
  int         mRefVal;

  function automatic int mCredit();
    return 50 * mCnt[0] + 10 * mCnt[1] + 5 * mCnt[2] + mCnt[3];
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) mCnt[i] = 0;
    mPhase = P_COL; mItem = 2'b00; mRej = 1'b0; mRefV = 1'b0; mRefVal = 0;
  endfunction

  function automatic void modelEdge(input logic cv, input logic [1:0] ct, input logic sv,
                                    input logic [1:0] si, input logic ca, input logic [1:0] svc);
    mRej = 1'b0; mRefV = 1'b0; mRefVal = 0;
    if (mPhase == P_COL) begin
      if (cv) begin
        if (mCnt[ct] < 3) mCnt[ct] = mCnt[ct] + 1;
        else mRej = 1'b1;
      end
      if (ca) begin
        mRefV = 1'b1; mRefVal = mCredit();
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
      end else if (sv && si != 2'b00) begin
        mItem = si; mPhase = P_ISS;
      end
    end else begin
      mRej = cv;
      if (mPhase == P_ISS && svc == 2'b01) begin
        for (int i = 0; i < 4; i++) mCnt[i] = 0;
        mItem = 2'b00; mPhase = P_WAIT;
      end else if (mPhase == P_WAIT && svc == 2'b00) begin
        mPhase = P_COL;
      end
    end
  endfunction

  function automatic logic [28:0] expVec();
    return {2'(mCnt[0]), 2'(mCnt[1]), 2'(mCnt[2]), 2'(mCnt[3]),
            (mPhase == P_ISS) ? mItem : 2'b00, (mPhase == P_COL), 8'(mCredit()),
            mRej, mRefV, 8'(mRefVal)};
  endfunction

  task automatic step(input logic cv, input logic [1:0] ct, input logic sv,
                      input logic [1:0] si, input logic ca, input logic [1:0] svc);
    coinValid = cv; coinType = ct; selValid = sv; selItem = si; cancel = ca; serviceTypeIn = svc;
    @(posedge clk);
    modelEdge(cv, ct, sv, si, ca, svc);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    coinValid = 1'b0; coinType = 2'b00; selValid = 1'b0; selItem = 2'b00; cancel = 1'b0;
    serviceTypeIn = 2'b01;
    @(posedge clk);
    modelReset();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checkCount++;
    if ({coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn} !== 10'd0) begin
      $display("FAIL reset_counts got %b required 0",
               {coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn});
    end else passCount++;
    checkCount++;
    if ({ready, creditValue, coinReject, refundValid, refundValue} !== {1'b1, 8'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_outputs got rdy=%b cr=%0d rej=%b rv=%b rval=%0d required rdy=1 rest 0",
               ready, creditValue, coinReject, refundValid, refundValue);
    end else passCount++;
  endtask

  task automatic test_purchase();
    logic [1:0] types[4];
    int         credits[4];
    types = '{2'b00, 2'b01, 2'b11, 2'b11};
    credits = '{50, 60, 61, 62};
    doReset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, types[i], 1'b0, 2'b00, 1'b0, 2'b01);
      checkCount++;
      if (creditValue !== 8'(credits[i])) begin
        $display("FAIL purchase_credit[%0d] got %0d required %0d", i, creditValue, credits[i]);
      end else passCount++;
    end
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b01);
    checkCount++;
    if ({coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn, ready} !==
        {2'd1, 2'd1, 2'd0, 2'd2, 2'b01, 1'b0}) begin
      $display("FAIL purchase_issue got %0d/%0d/%0d/%0d item=%b rdy=%b required 1/1/0/2 item=01 rdy=0",
               coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn, ready);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if ({itemTypeIn, ready, creditValue} !== {2'b00, 1'b0, 8'd0}) begin
      $display("FAIL purchase_consumed got item=%b rdy=%b cr=%0d required item=00 rdy=0 cr=0",
               itemTypeIn, ready, creditValue);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10);
    checkCount++;
    if (ready !== 1'b0) begin
      $display("FAIL purchase_busy_ready got %b required 0", ready);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    checkCount++;
    if ({ready, creditValue} !== {1'b1, 8'd0}) begin
      $display("FAIL purchase_done got rdy=%b cr=%0d required rdy=1 cr=0", ready, creditValue);
    end else passCount++;
  endtask

  task automatic test_saturate();
    doReset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if ({coinReject, creditValue} !== {1'b0, 8'd15}) begin
      $display("FAIL saturate_third got rej=%b cr=%0d required rej=0 cr=15", coinReject, creditValue);
    end else passCount++;
    step(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if ({coinReject, coinInNTD_5, creditValue} !== {1'b1, 2'd3, 8'd15}) begin
      $display("FAIL saturate_fourth got rej=%b c5=%0d cr=%0d required rej=1 c5=3 cr=15",
               coinReject, coinInNTD_5, creditValue);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if (coinReject !== 1'b0) begin
      $display("FAIL saturate_pulse_width got %b required 0", coinReject);
    end else passCount++;
  endtask

  task automatic test_cancel();
    doReset();
    step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01);
    step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01);
    step(1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 2'b01);
    checkCount++;
    if ({refundValid, refundValue, creditValue, ready} !== {1'b1, 8'd21, 8'd0, 1'b1}) begin
      $display("FAIL cancel_refund got rv=%b rval=%0d cr=%0d rdy=%b required rv=1 rval=21 cr=0 rdy=1",
               refundValid, refundValue, creditValue, ready);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if ({refundValid, refundValue} !== {1'b0, 8'd0}) begin
      $display("FAIL cancel_pulse_width got rv=%b rval=%0d required 0/0", refundValid, refundValue);
    end else passCount++;
  endtask

  task automatic test_busy_hold();
    doReset();
    step(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10);
    step(1'b0, 2'b00, 1'b1, 2'b11, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if ({itemTypeIn, coinInNTD_50, creditValue, ready} !== {2'b11, 2'd1, 8'd50, 1'b0}) begin
        $display("FAIL busy_hold[%0d] got item=%b c50=%0d cr=%0d rdy=%b required 11/1/50/0",
                 i, itemTypeIn, coinInNTD_50, creditValue, ready);
      end else passCount++;
      step(1'b0, 2'b00, 1'b0, 2'b00, (i == 2), (i == 4) ? 2'b01 : 2'b10);
    end
    checkCount++;
    if ({itemTypeIn, creditValue, refundValid} !== {2'b00, 8'd0, 1'b0}) begin
      $display("FAIL busy_consume got item=%b cr=%0d rv=%b required 00/0/0", itemTypeIn, creditValue, refundValid);
    end else passCount++;
    step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10);
    checkCount++;
    if ({coinReject, coinInNTD_10, ready} !== {1'b1, 2'd0, 1'b0}) begin
      $display("FAIL wait_coin_reject got rej=%b c10=%0d rdy=%b required 1/0/0", coinReject, coinInNTD_10, ready);
    end else passCount++;
    step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
    checkCount++;
    if (ready !== 1'b1) begin
      $display("FAIL wait_exit_ready got %b required 1", ready);
    end else passCount++;
  endtask

  task automatic test_reset_in_issue();
    doReset();
    step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 2'b10);
    checkCount++;
    if (itemTypeIn !== 2'b10) begin
      $display("FAIL issue_before_reset got %b required 10", itemTypeIn);
    end else passCount++;
    doReset();
    checkCount++;
    if ({coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn, ready} !== {10'd0, 1'b1}) begin
      $display("FAIL reset_in_issue got %b required 00000000000 1",
               {coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn, ready});
    end else passCount++;
  endtask

  task automatic test_collision();
    doReset();
    step(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01);
    step(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01);
    checkCount++;
    if ({ready, itemTypeIn, creditValue} !== {1'b1, 2'b00, 8'd10}) begin
      $display("FAIL none_select got rdy=%b item=%b cr=%0d required 1/00/10", ready, itemTypeIn, creditValue);
    end else passCount++;
    step(1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01);
    checkCount++;
    if ({ready, itemTypeIn, refundValid, refundValue} !== {1'b1, 2'b00, 1'b1, 8'd10}) begin
      $display("FAIL cancel_wins got rdy=%b item=%b rv=%b rval=%0d required 1/00/1/10",
               ready, itemTypeIn, refundValid, refundValue);
    end else passCount++;
  endtask

  task automatic test_random();
    logic [28:0] got, exp;
    logic [1:0]  svc;
    doReset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        doReset();
      end else begin
        svc = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
        step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
             2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0), svc);
      end
      got = {coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn, ready,
             creditValue, coinReject, refundValid, refundValue};
      exp = expVec();
      checkCount++;
      if (got !== exp) begin
        $display("FAIL random[%0d] got %h required %h", i, got, exp);
      end else passCount++;
    end
  endtask

  initial begin
    reset = 1'b0;
    coinValid = 1'b0; coinType = 2'b00; selValid = 1'b0; selItem = 2'b00; cancel = 1'b0;
    serviceTypeIn = 2'b00;
    modelReset();
    test_reset();
    test_purchase();
    test_saturate();
    test_cancel();
    test_busy_hold();
    test_reset_in_issue();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/coin_collector.md
# coin_collector

Front-end stage directly upstream of the vending machine core. Accepts one coin per cycle from the coin slot and one item selection from the keypad, and accumulates per-denomination coin counts. On selection it presents a single transaction request (coin counts plus item type) to the core in the encoding the core samples while in SERVICE_ON. It then holds off new input until the core completes the service.

## Interface
Parameters: none. All widths are fixed by the core's port widths.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- coinValid  in  1  one coin inserted this cycle
- coinType  in  2  denomination of the inserted coin: 00=NTD_50, 01=NTD_10, 10=NTD_5, 11=NTD_1
- selValid  in  1  keypad selection strobe
- selItem  in  2  item code: 00=NONE, 01=A, 10=B, 11=C
- cancel  in  1  refund request
- serviceTypeIn  in  2  core service state: 00=OFF, 01=ON, 10=BUSY, 11 treated as not-ON
- coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1  out  2 each  coin counts presented to the core
- itemTypeIn  out  2  item presented to the core; non-NONE only in ISSUE
- ready  out  1  high in COLLECT
- creditValue  out  8  running credit = 50·c50 + 10·c10 + 5·c5 + c1
- coinReject  out  1  one-cycle pulse; the coin from the previous cycle was returned
- refundValid  out  1  one-cycle pulse on cancel completion
- refundValue  out  8  credit refunded; valid while refundValid is high, 0 otherwise

## Operation
- Internal counters c50, c10, c5, c1 are 2 bits each and saturate at 3.
- Maximum credit is 198, which fits in 8 bits without wrap.
- coinIn* outputs always equal the internal counters.
- FSM has three states: COLLECT, ISSUE, WAIT.
- COLLECT, cancel=1:
  - refundValue ← credit, including any coin valid in the same cycle, provided that coin is not rejected.
  - refundValid pulses; counters clear; state stays COLLECT.
  - cancel has priority over selValid.
- COLLECT, coinValid=1:
  - If the addressed counter is below 3, increment it.
  - Otherwise leave counters unchanged and set coinReject for the next cycle.
- COLLECT, selValid=1, selItem≠NONE, cancel=0:
  - Latch selItem and go to ISSUE.
  - A coin accepted in the same cycle is included in the request.
  - selValid with selItem=NONE is ignored.
  - Zero-credit selections are issued; the core handles insufficient credit.
- ISSUE:
  - itemTypeIn = latched item.
  - If serviceTypeIn==ON, the core consumes the request at this edge: clear counters and item, go to WAIT.
  - Otherwise hold all outputs unchanged and stay in ISSUE.
  - cancel is ignored.
- WAIT: leave for COLLECT on the edge where serviceTypeIn==OFF. The core returns to ON in the following cycle.
- Any coinValid outside COLLECT is rejected: coinReject pulses and counters are unchanged.
- selValid and cancel outside COLLECT are ignored.
- Reset (synchronous, mid-transaction included): state=COLLECT and all counters cleared.
  - Every output resets to 0 except ready, which is 1.
  - Coins held at reset are lost; this matches the core, which resets at the same time.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Coin sampled at edge t: counters, creditValue and coinReject update after edge t.
- Selection sampled at edge t: ISSUE outputs valid from t+1. If the core is in ON at cycle t+1, it latches the request at edge t+2 and itemTypeIn returns to NONE after t+2.
- ready drops with entry to ISSUE and rises the cycle after serviceTypeIn==OFF is sampled.
- refundValid and coinReject are exactly one cycle wide. Back-to-back events produce back-to-back pulses.

## Test plan
- Reset, then coins 50,10,1,1 on consecutive cycles, then select A:
  - creditValue sequence is 50, 60, 61, 62.
  - ISSUE drives coinIn 50/10/5/1 = 1/1/0/2 and itemTypeIn=01 for one cycle with the core in ON.
  - After the core passes through BUSY then OFF, ready=1 and creditValue=0.
- Four NTD_5 coins in COLLECT: the 4th raises coinReject for one cycle; c5=3, creditValue=15.
- Coins 10,10 then cancel asserted together with a coin 1: refundValid pulses with refundValue=21; creditValue=0.
- Select C while serviceTypeIn=BUSY for 5 cycles:
  - Request held unchanged in ISSUE.
  - Consumed on the first ON cycle.
  - A coin inserted during WAIT is rejected.
- Reset asserted low while in ISSUE: next cycle all counters are 0, itemTypeIn=00, ready=1.
- selValid with selItem=00 plus cancel/select collision: a NONE select is ignored; when cancel and select coincide, cancel wins and there is no ISSUE.
